// File: rtl/otter_fetch_stage.sv
// OTTER instruction-fetch stage: owns the PC, issues synchronous-read requests to
// instruction memory and presents {valid, pc, instr, fault} to decode.
module otter_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             STALL,
  input  logic             BR_TAKEN,
  input  logic [31:0]      BR_TARGET,
  output logic [31:0]      IMEM_ADDR,
  output logic             IMEM_RDEN,
  input  logic [31:0]      IMEM_DATA,
  output logic             IFID_VALID,
  output logic [31:0]      IFID_PC,
  output logic [31:0]      IFID_INSTR,
  output logic             IFID_FAULT,
  output logic [CNT_W-1:0] FETCH_CNT
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [31:0]      pc_q;
  logic [31:0]      req_pc_q;
  logic [31:0]      held_instr_q;
  logic             req_valid_q;
  logic             fault_q;
  logic             hold_q;
  logic [CNT_W-1:0] fetch_cnt_q;

  logic pc_misaligned;
  logic advance;

  assign pc_misaligned = |pc_q[1:0];
  assign advance       = !STALL && !BR_TAKEN;

  // A misaligned PC never touches memory; the slot is filled with a NOP instead.
  assign IMEM_ADDR = pc_q;
  assign IMEM_RDEN = !RST && advance && !pc_misaligned;

  // Control state. A redirect outranks a stall, and reset outranks both.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
      hold_q      <= 1'b0;
      fault_q     <= 1'b0;
      fetch_cnt_q <= '0;
    end else if (BR_TAKEN) begin
      pc_q        <= BR_TARGET;
      req_valid_q <= 1'b0;
      hold_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else if (STALL) begin
      hold_q <= 1'b1;
    end else begin
      pc_q        <= pc_q + 32'd4;
      req_valid_q <= 1'b1;
      fault_q     <= pc_misaligned;
      hold_q      <= 1'b0;
      if (req_valid_q) fetch_cnt_q <= fetch_cnt_q + CNT_ONE;
    end
  end

  // NOTE: pure data registers carry no reset; they are only observed once the
  // matching valid/hold flag, which is reset, says they are meaningful.
  always_ff @(posedge CLK) begin
    if (advance) req_pc_q <= pc_q;
    // Memory data is only good for one cycle, so capture it on the first stall edge.
    if (STALL && !hold_q) held_instr_q <= IMEM_DATA;
  end

  // NOTE: every branch of this mux assigns IFID_INSTR, so no latch is inferred.
  always_comb begin
    IFID_INSTR = IMEM_DATA;
    if (fault_q)     IFID_INSTR = NOP_INSTR;
    else if (hold_q) IFID_INSTR = held_instr_q;
  end

  assign IFID_VALID = req_valid_q;
  assign IFID_PC    = req_pc_q;
  assign IFID_FAULT = fault_q;
  assign FETCH_CNT  = fetch_cnt_q;

endmodule
